mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Multicycle control unit sitting directly upstream of the register-file/ALU datapath.
- Fetches 32-bit RV32I-subset instructions over a valid handshake and owns the PC.
- Decodes each instruction into datapath controls (register indices, immediate, ALU function, mux selects, write strobes) and sequences data-memory accesses.
- Resolves branches and jumps using the datapath flags and the PCReg feedback.

Parameters:
NBITS, 8, datapath/PC width
NREGS, 32, register count; index width is $clog2(NREGS)
WIDTH_ALUF, 4, ALUControl width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
imem_req  out  1  instruction fetch request
imem_addr  out  NBITS  fetch address (= PC)
imem_valid  in  1  imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
RS1, RS2, RD  out  $clog2(NREGS)  register indices to datapath
IMM  out  NBITS  sign-extended immediate, truncated to NBITS
ALUControl  out  WIDTH_ALUF  ALU function
ALUSrc, MemtoReg, RegWrite, link  out  1  datapath selects/strobe
pclink  out  NBITS  PC+4 for JAL/JALR link
Zero, Neg, Carry  in  1  datapath flags
PCReg  in  NBITS  rs1 value for JALR
MemRead, MemWrite  out  1  data-memory strobes
mem_ready  in  1  data-memory access complete
halt  out  1  illegal instruction trapped

Behaviour:
- Reset (reset=0, async):
  - State=FETCH, PC=0, IR=0x00000013 (addi x0,x0,0).
  - All strobes (RegWrite, MemRead, MemWrite, link, halt) = 0.
  - imem_req goes to 1 on the first clock after release.
- States:
  - FETCH:
    - imem_req=1, imem_addr=PC.
    - On imem_valid: latch IR and go to DECODE.
    - Otherwise hold; no timeout.
  - DECODE:
    - One cycle; fields driven from IR so the register file settles.
    - Unsupported opcode/funct -> TRAP; otherwise -> EXEC.
  - EXEC:
    - OP (ADD, SUB, SLTU) and OP-IMM (ADDI, SLTIU): RegWrite=1 for exactly this cycle, PC+=4, -> FETCH.
    - BEQ/BNE: ALUControl=SUB, ALUSrc=0. Taken when Zero (BEQ) or !Zero (BNE): PC=PC+IMM, else PC+=4. No RegWrite. -> FETCH.
    - JAL: link=1, RegWrite=1, pclink=PC+4, PC=PC+IMM.
    - JALR: link=1, RegWrite=1, pclink=PC+4, PC=(PCReg+IMM)&~1.
    - LW/SW: ALUControl=ADD, ALUSrc=1, -> MEM.
  - MEM:
    - MemRead (LW) or MemWrite (SW) held high until mem_ready.
    - On mem_ready: LW pulses RegWrite with MemtoReg=1 in that same cycle; PC+=4; -> FETCH.
  - TRAP: halt=1; all strobes 0; stays until reset.
- Decoded-field hold: RS1/RS2/RD/IMM/ALUControl/ALUSrc/MemtoReg derive combinationally from IR and stay stable from DECODE through instruction end.
- Arithmetic: all PC math is modulo 2^NBITS (wraps, e.g. 0xFC+4=0x00). IMM bits above NBITS are discarded.
- rd=x0: RegWrite still pulses; the datapath ignores it.
- Simultaneous events: imem_valid outside FETCH and mem_ready outside MEM are ignored.
- Reset mid-operation: abandons any access immediately; MemWrite drops asynchronously.
- Strobe exclusivity: at most one of RegWrite/MemWrite is asserted in a cycle; RegWrite never lasts more than 1 cycle per instruction.

Decomposition:
- Package mc_pkg:
  - State enum (FETCH, DECODE, EXEC, MEM, TRAP).
  - Opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR).
  - ALU codes ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLTU=4'b0011.
- Sub-module mc_decoder: purely combinational IR -> fields/immediate/ALU code/illegal flag.
- mc_controller holds PC, IR, FSM.

Test Plan:
- Reset then imem_valid after 2 wait cycles with addi x1,x0,5: imem_req high 3 cycles; RegWrite single pulse in EXEC with RD=1, IMM=5, ALUSrc=1; PC=4.
- beq x1,x2,+8 at PC=0x10:
  - Zero=1 -> PC=0x18.
  - Zero=0 -> PC=0x14.
  - RegWrite stays 0 in both cases.
- lw x3,4(x1) with mem_ready after 3 cycles: MemRead high exactly 3 cycles; RegWrite and MemtoReg high only on the ready cycle; sw equivalent gives MemWrite and no RegWrite.
- jal x1,-8 at PC=0x04: link=1, pclink=0x08, PC=0xFC (wrap); then jalr x0,0(x1) with PCReg=0x09 -> PC=0x08.
- IR=0xFFFFFFFF: TRAP, halt=1 persists 20 cycles, imem_req=0; reset low clears halt, PC=0.
- reset driven low mid-MEM with MemWrite high: MemWrite falls before the next clock edge; after release, fetch from PC=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle control unit: FSM states,
// RV32I opcodes, ALU function codes and immediate-format helpers.
package mc_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    TRAP   = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_BRANCH = 3'd1,
    CL_JAL    = 3'd2,
    CL_JALR   = 3'd3,
    CL_LOAD   = 3'd4,
    CL_STORE  = 3'd5
  } iclass_e;

  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b0011;

  localparam logic [31:0] IR_NOP = 32'h0000_0013;

  function automatic logic [31:0] imm_itype(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:20]};
  endfunction

  function automatic logic [31:0] imm_stype(input logic [31:0] ir);
    return {{20{ir[31]}}, ir[31:25], ir[11:7]};
  endfunction

  function automatic logic [31:0] imm_btype(input logic [31:0] ir);
    return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_jtype(input logic [31:0] ir);
    return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/mc_if.sv
// Bus between the control unit and its surroundings: instruction fetch,
// datapath controls/flags and data-memory strobes.
interface mc_if #(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
);
  localparam int RW = $clog2(NREGS);

  logic                  imem_req;
  logic [NBITS-1:0]      imem_addr;
  logic                  imem_valid;
  logic [31:0]           imem_rdata;
  logic [RW-1:0]         RS1;
  logic [RW-1:0]         RS2;
  logic [RW-1:0]         RD;
  logic [NBITS-1:0]      IMM;
  logic [WIDTH_ALUF-1:0] ALUControl;
  logic                  ALUSrc;
  logic                  MemtoReg;
  logic                  RegWrite;
  logic                  link;
  logic [NBITS-1:0]      pclink;
  logic                  Zero;
  logic                  Neg;
  logic                  Carry;
  logic [NBITS-1:0]      PCReg;
  logic                  MemRead;
  logic                  MemWrite;
  logic                  mem_ready;
  logic                  halt;

  modport master (
    output imem_req, imem_addr, RS1, RS2, RD, IMM, ALUControl, ALUSrc,
           MemtoReg, RegWrite, link, pclink, MemRead, MemWrite, halt,
    input  imem_valid, imem_rdata, Zero, Neg, Carry, PCReg, mem_ready
  );

  modport slave (
    input  imem_req, imem_addr, RS1, RS2, RD, IMM, ALUControl, ALUSrc,
           MemtoReg, RegWrite, link, pclink, MemRead, MemWrite, halt,
    output imem_valid, imem_rdata, Zero, Neg, Carry, PCReg, mem_ready
  );
endinterface

// File: rtl/mc_decoder.sv
// Purely combinational decode of the instruction register into register
// indices, truncated immediate, ALU function, instruction class and illegal flag.
module mc_decoder
  import mc_pkg::*;
#(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input  logic [31:0]              ir_i,
  output logic [$clog2(NREGS)-1:0] rs1_o,
  output logic [$clog2(NREGS)-1:0] rs2_o,
  output logic [$clog2(NREGS)-1:0] rd_o,
  output logic [NBITS-1:0]         imm_o,
  output logic [WIDTH_ALUF-1:0]    alu_ctrl_o,
  output logic                     alu_src_o,
  output iclass_e                  iclass_o,
  output logic                     bne_o,
  output logic                     illegal_o
);
  localparam int RW = $clog2(NREGS);

  logic [6:0]  opcode_s;
  logic [2:0]  funct3_s;
  logic [6:0]  funct7_s;
  logic [31:0] imm_full_s;
  logic [3:0]  alu_s;
  logic        alu_src_s;
  iclass_e     iclass_s;
  logic        illegal_s;
  logic        unused_s;

  assign opcode_s = ir_i[6:0];
  assign funct3_s = ir_i[14:12];
  assign funct7_s = ir_i[31:25];
  assign rs1_o    = ir_i[15 +: RW];
  assign rs2_o    = ir_i[20 +: RW];
  assign rd_o     = ir_i[7 +: RW];

  // Opcode/funct decode; anything outside the supported subset is illegal
  always_comb begin
    imm_full_s = 32'd0;
    alu_s      = ALU_ADD;
    alu_src_s  = 1'b0;
    iclass_s   = CL_ALU;
    illegal_s  = 1'b0;
    case (opcode_s)
      OP: begin
        case ({funct7_s, funct3_s})
          {7'b0000000, 3'b000}: alu_s = ALU_ADD;
          {7'b0100000, 3'b000}: alu_s = ALU_SUB;
          {7'b0000000, 3'b011}: alu_s = ALU_SLTU;
          default:              illegal_s = 1'b1;
        endcase
      end
      OP_IMM: begin
        alu_src_s  = 1'b1;
        imm_full_s = imm_itype(ir_i);
        case (funct3_s)
          3'b000:  alu_s = ALU_ADD;
          3'b011:  alu_s = ALU_SLTU;
          default: illegal_s = 1'b1;
        endcase
      end
      LOAD: begin
        iclass_s   = CL_LOAD;
        alu_src_s  = 1'b1;
        imm_full_s = imm_itype(ir_i);
        illegal_s  = (funct3_s != 3'b010);
      end
      STORE: begin
        iclass_s   = CL_STORE;
        alu_src_s  = 1'b1;
        imm_full_s = imm_stype(ir_i);
        illegal_s  = (funct3_s != 3'b010);
      end
      BRANCH: begin
        iclass_s   = CL_BRANCH;
        alu_s      = ALU_SUB;
        imm_full_s = imm_btype(ir_i);
        illegal_s  = (funct3_s[2:1] != 2'b00);
      end
      JAL: begin
        iclass_s   = CL_JAL;
        imm_full_s = imm_jtype(ir_i);
      end
      JALR: begin
        iclass_s   = CL_JALR;
        alu_src_s  = 1'b1;
        imm_full_s = imm_itype(ir_i);
        illegal_s  = (funct3_s != 3'b000);
      end
      default: illegal_s = 1'b1;
    endcase
  end

  assign imm_o      = imm_full_s[NBITS-1:0];
  assign alu_ctrl_o = WIDTH_ALUF'(alu_s);
  assign alu_src_o  = alu_src_s;
  assign iclass_o   = iclass_s;
  assign bne_o      = funct3_s[0];
  assign illegal_o  = illegal_s;
  // Immediate bits above the datapath width are intentionally dropped
  assign unused_s   = ^imm_full_s[31:NBITS];

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: owns PC and IR, sequences fetch/decode/execute/
// memory, resolves branches and jumps, and traps on illegal instructions.
module mc_controller
  import mc_pkg::*;
#(
  parameter int NBITS      = 8,
  parameter int NREGS      = 32,
  parameter int WIDTH_ALUF = 4
) (
  input logic  clock,
  input logic  reset,
  mc_if.master bus
);
  localparam int               RW      = $clog2(NREGS);
  localparam logic [NBITS-1:0] PC_STEP = NBITS'(4);

  state_e           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic             live_q;

  logic [RW-1:0]         rs1_s, rs2_s, rd_s;
  logic [NBITS-1:0]      imm_s;
  logic [WIDTH_ALUF-1:0] alu_ctrl_s;
  logic                  alu_src_s;
  iclass_e               iclass_s;
  logic                  bne_s;
  logic                  illegal_s;

  logic [NBITS-1:0] pc_seq_s, pc_rel_s, jalr_sum_s, jalr_tgt_s;
  logic             taken_s, is_load_s, is_store_s;
  logic             req_s, reg_write_s, link_s, mem_read_s, mem_write_s;
  logic             mem_to_reg_s, halt_s, unused_s;

  mc_decoder #(
    .NBITS      (NBITS),
    .NREGS      (NREGS),
    .WIDTH_ALUF (WIDTH_ALUF)
  ) u_decoder (
    .ir_i       (ir_q),
    .rs1_o      (rs1_s),
    .rs2_o      (rs2_s),
    .rd_o       (rd_s),
    .imm_o      (imm_s),
    .alu_ctrl_o (alu_ctrl_s),
    .alu_src_o  (alu_src_s),
    .iclass_o   (iclass_s),
    .bne_o      (bne_s),
    .illegal_o  (illegal_s)
  );

  assign pc_seq_s   = pc_q + PC_STEP;
  assign pc_rel_s   = pc_q + imm_s;
  assign jalr_sum_s = bus.PCReg + imm_s;
  assign jalr_tgt_s = {jalr_sum_s[NBITS-1:1], 1'b0};
  assign taken_s    = bus.Zero ^ bne_s;
  assign is_load_s  = (iclass_s == CL_LOAD);
  assign is_store_s = (iclass_s == CL_STORE);

  // State, PC and IR registers; live_q keeps the fetch request low until the first edge after reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= {NBITS{1'b0}};
      ir_q    <= IR_NOP;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state, PC update and per-state strobes
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    req_s        = 1'b0;
    reg_write_s  = 1'b0;
    link_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    mem_to_reg_s = 1'b0;
    halt_s       = 1'b0;
    case (state_q)
      FETCH: begin
        req_s = live_q;
        if (live_q && bus.imem_valid) begin
          ir_d    = bus.imem_rdata;
          state_d = DECODE;
        end else begin
          state_d = FETCH;
        end
      end
      DECODE: state_d = illegal_s ? TRAP : EXEC;
      EXEC: begin
        state_d = FETCH;
        case (iclass_s)
          CL_ALU: begin
            reg_write_s = 1'b1;
            pc_d        = pc_seq_s;
          end
          CL_BRANCH: pc_d = taken_s ? pc_rel_s : pc_seq_s;
          CL_JAL: begin
            link_s      = 1'b1;
            reg_write_s = 1'b1;
            pc_d        = pc_rel_s;
          end
          CL_JALR: begin
            link_s      = 1'b1;
            reg_write_s = 1'b1;
            pc_d        = jalr_tgt_s;
          end
          CL_LOAD, CL_STORE: state_d = MEM;
          default: state_d = TRAP;
        endcase
      end
      MEM: begin
        mem_read_s  = is_load_s;
        mem_write_s = is_store_s;
        if (bus.mem_ready) begin
          reg_write_s  = is_load_s;
          mem_to_reg_s = is_load_s;
          pc_d         = pc_seq_s;
          state_d      = FETCH;
        end else begin
          state_d = MEM;
        end
      end
      TRAP: begin
        halt_s  = 1'b1;
        state_d = TRAP;
      end
      default: state_d = TRAP;
    endcase
  end

  assign bus.imem_req   = req_s;
  assign bus.imem_addr  = pc_q;
  assign bus.RS1        = rs1_s;
  assign bus.RS2        = rs2_s;
  assign bus.RD         = rd_s;
  assign bus.IMM        = imm_s;
  assign bus.ALUControl = alu_ctrl_s;
  assign bus.ALUSrc     = alu_src_s;
  assign bus.MemtoReg   = mem_to_reg_s;
  assign bus.RegWrite   = reg_write_s;
  assign bus.link       = link_s;
  assign bus.pclink     = pc_seq_s;
  assign bus.MemRead    = mem_read_s;
  assign bus.MemWrite   = mem_write_s;
  assign bus.halt       = halt_s;
  // Negative/carry flags are not needed by the supported branch subset
  assign unused_s       = bus.Neg ^ bus.Carry;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed walk through the key scenarios plus
// randomized instructions checked against an instruction-level reference model.
module tb_mc_controller;

  localparam int K_ADD = 0, K_SUB = 1, K_SLTU = 2, K_ADDI = 3, K_SLTIU = 4, K_LW = 5;
  localparam int K_SW = 6, K_BEQ = 7, K_BNE = 8, K_JAL = 9, K_JALR = 10;

  logic clock;
  logic reset;
  int   tests;
  int   fails;
  int   model_pc;

  mc_if #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) bus ();

  mc_controller #(.NBITS(8), .NREGS(32), .WIDTH_ALUF(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] encode(input int k, input int rd, input int rs1, input int rs2, input int imm);
    logic [4:0]  d, a, b;
    logic [20:0] im;
    logic [31:0] v;
    d = rd[4:0]; a = rs1[4:0]; b = rs2[4:0]; im = imm[20:0];
    case (k)
      K_ADD:   v = {7'h00, b, a, 3'b000, d, 7'h33};
      K_SUB:   v = {7'h20, b, a, 3'b000, d, 7'h33};
      K_SLTU:  v = {7'h00, b, a, 3'b011, d, 7'h33};
      K_ADDI:  v = {im[11:0], a, 3'b000, d, 7'h13};
      K_SLTIU: v = {im[11:0], a, 3'b011, d, 7'h13};
      K_LW:    v = {im[11:0], a, 3'b010, d, 7'h03};
      K_SW:    v = {im[11:5], b, a, 3'b010, im[4:0], 7'h23};
      K_BEQ:   v = {im[12], im[10:5], b, a, 3'b000, im[4:1], im[11], 7'h63};
      K_BNE:   v = {im[12], im[10:5], b, a, 3'b001, im[4:1], im[11], 7'h63};
      K_JAL:   v = {im[20], im[10:1], im[11], im[19:12], d, 7'h6f};
      K_JALR:  v = {im[11:0], a, 3'b000, d, 7'h67};
      default: v = 32'hFFFF_FFFF;
    endcase
    return v;
  endfunction

  function automatic int next_pc(input int k, input int pc, input int imm, input bit zero, input int pcreg);
    case (k)
      K_BEQ:   return zero ? ((pc + imm) & 255) : ((pc + 4) & 255);
      K_BNE:   return !zero ? ((pc + imm) & 255) : ((pc + 4) & 255);
      K_JAL:   return (pc + imm) & 255;
      K_JALR:  return (pcreg + imm) & 254;
      default: return (pc + 4) & 255;
    endcase
  endfunction

  function automatic int exp_alu(input int k);
    case (k)
      K_SUB, K_BEQ, K_BNE: return 8;
      K_SLTU, K_SLTIU:     return 3;
      default:             return 0;
    endcase
  endfunction

  function automatic int exp_src(input int k);
    return (k == K_ADDI || k == K_SLTIU || k == K_LW || k == K_SW) ? 1 : 0;
  endfunction

  task automatic check_fields(input string st, input int k, input int rd, input int rs1, input int rs2, input int imm);
    if (k != K_JAL) check({st, "_rs1"}, 32'(bus.RS1), rs1);
    if (k <= K_SLTU || k == K_SW || k == K_BEQ || k == K_BNE) check({st, "_rs2"}, 32'(bus.RS2), rs2);
    if (k != K_SW && k != K_BEQ && k != K_BNE) check({st, "_rd"}, 32'(bus.RD), rd);
    if (k >= K_ADDI) check({st, "_imm"}, 32'(bus.IMM), imm & 255);
    if (k != K_JAL && k != K_JALR) begin
      check({st, "_alu"}, 32'(bus.ALUControl), exp_alu(k));
      check({st, "_alusrc"}, 32'(bus.ALUSrc), exp_src(k));
    end
  endtask

  // Fetch (after fwait idle cycles), decode, execute and optionally MEM one instruction.
  task automatic run_instr(input int k, input int rd, input int rs1, input int rs2, input int imm,
                           input int fwait, input bit zero, input int pcreg, input int mwait);
    logic [31:0] instr;
    bit          is_mem, is_ld, is_jump, wr_exec;
    instr   = encode(k, rd, rs1, rs2, imm);
    is_mem  = (k == K_LW || k == K_SW);
    is_ld   = (k == K_LW);
    is_jump = (k == K_JAL || k == K_JALR);
    wr_exec = (k <= K_SLTIU) || is_jump;
    for (int i = 0; i <= fwait; i++) begin
      @(negedge clock);
      bus.imem_valid = (i == fwait);
      bus.imem_rdata = (i == fwait) ? instr : 32'($urandom());
      bus.mem_ready  = 1'($urandom_range(0, 1));
      #1;
      check("fetch_req", 32'(bus.imem_req), 32'd1);
      check("fetch_addr", 32'(bus.imem_addr), model_pc);
      check("fetch_rw", 32'(bus.RegWrite), 32'd0);
    end
    @(negedge clock);
    bus.imem_valid = 1'($urandom_range(0, 1));
    bus.imem_rdata = 32'($urandom());
    #1;
    check("dec_req", 32'(bus.imem_req), 32'd0);
    check("dec_rw", 32'(bus.RegWrite), 32'd0);
    check_fields("dec", k, rd, rs1, rs2, imm);
    @(negedge clock);
    bus.Zero      = zero;
    bus.PCReg     = 8'(pcreg);
    bus.Neg       = 1'($urandom_range(0, 1));
    bus.Carry     = 1'($urandom_range(0, 1));
    bus.mem_ready = 1'($urandom_range(0, 1));
    #1;
    check_fields("exec", k, rd, rs1, rs2, imm);
    check("exec_rw", 32'(bus.RegWrite), 32'(wr_exec));
    check("exec_link", 32'(bus.link), 32'(is_jump));
    check("exec_mr", 32'(bus.MemRead), 32'd0);
    check("exec_mw", 32'(bus.MemWrite), 32'd0);
    if (is_jump) check("exec_pclink", 32'(bus.pclink), (model_pc + 4) & 255);
    if (is_mem) begin
      for (int i = 0; i <= mwait; i++) begin
        @(negedge clock);
        bus.mem_ready = (i == mwait);
        #1;
        check("mem_mr", 32'(bus.MemRead), 32'(is_ld));
        check("mem_mw", 32'(bus.MemWrite), 32'(!is_ld));
        check("mem_rw", 32'(bus.RegWrite), 32'(is_ld && i == mwait));
        check("mem_m2r", 32'(bus.MemtoReg), 32'(is_ld && i == mwait));
        check_fields("mem", k, rd, rs1, rs2, imm);
      end
    end
    model_pc = next_pc(k, model_pc, imm, zero, pcreg);
  endtask

  initial begin
    int k;
    int imm;
    tests    = 0;
    fails    = 0;
    model_pc = 0;
    reset          = 1'b0;
    bus.imem_valid = 1'b0;
    bus.imem_rdata = 32'd0;
    bus.Zero       = 1'b0;
    bus.Neg        = 1'b0;
    bus.Carry      = 1'b0;
    bus.PCReg      = 8'd0;
    bus.mem_ready  = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_addr", 32'(bus.imem_addr), 32'd0);
    check("rst_rw", 32'(bus.RegWrite), 32'd0);
    check("rst_mr", 32'(bus.MemRead), 32'd0);
    check("rst_mw", 32'(bus.MemWrite), 32'd0);
    check("rst_link", 32'(bus.link), 32'd0);
    check("rst_halt", 32'(bus.halt), 32'd0);
    check("rst_nop_rd", 32'(bus.RD), 32'd0);
    check("rst_nop_imm", 32'(bus.IMM), 32'd0);
    check("rst_nop_alu", 32'(bus.ALUControl), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rel_req", 32'(bus.imem_req), 32'd0);

    // Directed scenarios: addi, jal wrap, jalr, lw/sw, beq taken/not taken
    run_instr(K_ADDI, 1, 0, 0, 5, 2, 1'b0, 0, 0);
    run_instr(K_JAL, 1, 0, 0, -8, 0, 1'b0, 0, 0);
    run_instr(K_JALR, 0, 1, 0, 0, 0, 1'b0, 9, 0);
    run_instr(K_LW, 3, 1, 0, 4, 1, 1'b0, 0, 2);
    run_instr(K_SW, 0, 1, 3, 4, 0, 1'b0, 0, 2);
    run_instr(K_BEQ, 0, 1, 2, 8, 0, 1'b1, 0, 0);
    run_instr(K_JAL, 0, 0, 0, -8, 0, 1'b0, 0, 0);
    run_instr(K_BEQ, 0, 1, 2, 8, 0, 1'b0, 0, 0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      k = int'($urandom_range(0, 10));
      if (k <= K_SLTU) imm = 0;
      else if (k == K_BEQ || k == K_BNE) imm = (int'($urandom_range(0, 4095)) - 2048) * 2;
      else if (k == K_JAL) imm = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      else imm = int'($urandom_range(0, 4095)) - 2048;
      run_instr(k, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                imm, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)));
    end

    // Illegal instruction traps until reset
    @(negedge clock);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = 32'hFFFF_FFFF;
    #1;
    check("trap_fetch_addr", 32'(bus.imem_addr), model_pc);
    @(negedge clock);
    bus.imem_valid = 1'b0;
    #1;
    check("trap_dec_halt", 32'(bus.halt), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      bus.imem_valid = 1'($urandom_range(0, 1));
      bus.mem_ready  = 1'($urandom_range(0, 1));
      #1;
      check("trap_halt", 32'(bus.halt), 32'd1);
      check("trap_req", 32'(bus.imem_req), 32'd0);
      check("trap_rw", 32'(bus.RegWrite), 32'd0);
      check("trap_mr", 32'(bus.MemRead), 32'd0);
      check("trap_mw", 32'(bus.MemWrite), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("trap_rst_halt", 32'(bus.halt), 32'd0);
    check("trap_rst_addr", 32'(bus.imem_addr), 32'd0);
    @(negedge clock);
    reset    = 1'b1;
    model_pc = 0;

    // Reset while a store is waiting in MEM
    @(negedge clock);
    bus.imem_valid = 1'b1;
    bus.imem_rdata = encode(K_SW, 0, 1, 3, 4);
    bus.mem_ready  = 1'b0;
    #1;
    check("mid_fetch_addr", 32'(bus.imem_addr), 32'd0);
    @(negedge clock);
    bus.imem_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #1;
    check("mid_mw_high", 32'(bus.MemWrite), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("mid_mw_async_drop", 32'(bus.MemWrite), 32'd0);
    check("mid_req_drop", 32'(bus.imem_req), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_instr(K_ADDI, 2, 0, 0, 1, 0, 1'b0, 0, 0);
    @(negedge clock);
    #1;
    check("final_addr", 32'(bus.imem_addr), model_pc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
